dm_store_buffer: RTL and testbench

Posted-store buffer between the CPU data port (`web_o`/`dm_addr_o`/`dm_data_o`/`dm_data_i`) and a variable-latency data memory with a req/gnt/rvalid interface. Stores retire into a FIFO immediately and drain to memory in the background. Loads take priority over draining, and each loaded byte is taken from the youngest buffered store to the same word when one exists. The block stalls the CPU only when the buffer is full or a load must go to memory.

---
 rtl/dm_store_buffer.sv | 168 ++++++++++++++++
 tb/tb_dm_store_buffer.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_store_buffer.sv
// Posted-store buffer between the CPU data port and a req/gnt/rvalid data memory.
// Stores post into a FIFO and drain in the background; loads forward bytes from buffered stores.
module dm_store_buffer #(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned ADDR_BITS = 32,
  parameter int unsigned DATA_BITS = 32,
  parameter int unsigned WEB_BITS  = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cpu_rd_i,
  input  logic [WEB_BITS-1:0]          cpu_web_i,
  input  logic [ADDR_BITS-1:0]         cpu_addr_i,
  input  logic [DATA_BITS-1:0]         cpu_wdata_i,
  output logic [DATA_BITS-1:0]         cpu_rdata_o,
  output logic                         stall_o,
  output logic                         mem_req_o,
  output logic                         mem_we_o,
  output logic [WEB_BITS-1:0]          mem_web_o,
  output logic [ADDR_BITS-1:0]         mem_addr_o,
  output logic [DATA_BITS-1:0]         mem_wdata_o,
  input  logic                         mem_gnt_i,
  input  logic                         mem_rvalid_i,
  input  logic [DATA_BITS-1:0]         mem_rdata_i,
  output logic                         sb_empty_o,
  output logic [$clog2(DEPTH+1)-1:0]   sb_count_o
);

  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
  localparam int unsigned WA_W   = ADDR_BITS - 2;
  localparam int unsigned BYTE_W = DATA_BITS / WEB_BITS;

  typedef enum logic [1:0] {IDLE, LD_REQ, LD_WAIT, LD_DONE} state_e;

  state_e               state_q;
  logic [WA_W-1:0]      ent_addr_q [DEPTH];
  logic [WEB_BITS-1:0]  ent_mask_q [DEPTH];
  logic [DATA_BITS-1:0] ent_data_q [DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]     count_q;
  logic [WA_W-1:0]      ld_addr_q;
  logic [WEB_BITS-1:0]  fwd_mask_q;
  logic [DATA_BITS-1:0] fwd_data_q, merge_q;

  logic [WA_W-1:0]      cpu_waddr;
  logic                 is_store, full, drain_c, pop_c, push_c, full_hit;
  logic [WEB_BITS-1:0]  fwd_mask;
  logic [DATA_BITS-1:0] fwd_data, merge_d;
  logic                 unused_addr_lsb;

  assign cpu_waddr       = cpu_addr_i[ADDR_BITS-1:2];
  assign unused_addr_lsb = ^cpu_addr_i[1:0];
  assign is_store        = ~&cpu_web_i;
  assign full            = (count_q == CNT_W'(DEPTH));
  assign drain_c         = (state_q == IDLE) && !cpu_rd_i && (count_q != '0);
  assign pop_c           = drain_c && mem_gnt_i;
  assign push_c          = (state_q == IDLE) && !cpu_rd_i && is_store && (!full || pop_c);
  assign full_hit        = &fwd_mask;
  assign sb_count_o      = count_q;
  assign sb_empty_o      = (count_q == '0);

  // Walk oldest to youngest so the youngest matching store owns each byte.
  always_comb begin
    logic [PTR_W-1:0] idx;
    fwd_mask = '0;
    fwd_data = '0;
    idx      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr_q + PTR_W'(i);
      if (CNT_W'(i) < count_q && ent_addr_q[idx] == cpu_waddr) begin
        for (int b = 0; b < WEB_BITS; b++) begin
          if (ent_mask_q[idx][b]) begin
            fwd_mask[b]                 = 1'b1;
            fwd_data[b*BYTE_W +: BYTE_W] = ent_data_q[idx][b*BYTE_W +: BYTE_W];
          end
        end
      end
    end
  end

  always_comb begin
    merge_d = '0;
    for (int b = 0; b < WEB_BITS; b++) begin
      merge_d[b*BYTE_W +: BYTE_W] = fwd_mask_q[b] ? fwd_data_q[b*BYTE_W +: BYTE_W]
                                                  : mem_rdata_i[b*BYTE_W +: BYTE_W];
    end
  end

  // CPU and memory side outputs decoded from the current state.
  always_comb begin
    stall_o     = 1'b0;
    cpu_rdata_o = '0;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_web_o   = '1;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    case (state_q)
      IDLE: begin
        if (cpu_rd_i) begin
          if (full_hit) cpu_rdata_o = fwd_data;
          else          stall_o     = 1'b1;
        end else begin
          if (is_store && !push_c) stall_o = 1'b1;
          if (count_q != '0) begin
            mem_req_o   = 1'b1;
            mem_we_o    = 1'b1;
            mem_web_o   = ~ent_mask_q[rd_ptr_q];
            mem_addr_o  = {ent_addr_q[rd_ptr_q], 2'b00};
            mem_wdata_o = ent_data_q[rd_ptr_q];
          end
        end
      end
      LD_REQ: begin
        stall_o    = 1'b1;
        mem_req_o  = 1'b1;
        mem_addr_o = {ld_addr_q, 2'b00};
      end
      LD_WAIT: stall_o = 1'b1;
      LD_DONE: cpu_rdata_o = merge_q;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ld_addr_q  <= '0;
      fwd_mask_q <= '0;
      fwd_data_q <= '0;
      merge_q    <= '0;
    end else begin
      if (push_c) begin
        ent_addr_q[wr_ptr_q] <= cpu_waddr;
        ent_mask_q[wr_ptr_q] <= ~cpu_web_i;
        ent_data_q[wr_ptr_q] <= cpu_wdata_i;
        wr_ptr_q             <= wr_ptr_q + PTR_W'(1);
      end
      if (pop_c) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_q + CNT_W'(push_c) - CNT_W'(pop_c);

      case (state_q)
        IDLE: begin
          if (cpu_rd_i && !full_hit) begin
            ld_addr_q  <= cpu_waddr;
            fwd_mask_q <= fwd_mask;
            fwd_data_q <= fwd_data;
            state_q    <= LD_REQ;
          end
        end
        LD_REQ:  if (mem_gnt_i) state_q <= LD_WAIT;
        LD_WAIT: begin
          if (mem_rvalid_i) begin
            merge_q <= merge_d;
            state_q <= LD_DONE;
          end
        end
        LD_DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dm_store_buffer.sv
// Directed bench for dm_store_buffer with a variable-latency memory responder.
module tb_dm_store_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_rd_i;
  logic [3:0]  cpu_web_i;
  logic [31:0] cpu_addr_i, cpu_wdata_i, cpu_rdata_o;
  logic        stall_o, mem_req_o, mem_we_o;
  logic [3:0]  mem_web_o;
  logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
  logic        mem_gnt_i, mem_rvalid_i;
  logic        sb_empty_o;
  logic [2:0]  sb_count_o;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  dm_store_buffer dut (
    .clk(clk), .rst(rst), .cpu_rd_i(cpu_rd_i), .cpu_web_i(cpu_web_i),
    .cpu_addr_i(cpu_addr_i), .cpu_wdata_i(cpu_wdata_i), .cpu_rdata_o(cpu_rdata_o),
    .stall_o(stall_o), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
    .mem_web_o(mem_web_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .sb_empty_o(sb_empty_o), .sb_count_o(sb_count_o)
  );

  // Memory responder: byte-enabled writes, reads return rv_lat cycles after grant.
  logic [31:0] mem_model [logic [29:0]];
  logic [31:0] drn_addr [$];
  logic [31:0] drn_data [$];
  int          rv_lat = 1;
  int          rv_cnt = 0;
  logic        rv_q = 1'b0, rv_force = 1'b0;
  logic [31:0] rv_data = '0, force_data = '0;
  logic [29:0] rv_word = '0;

  assign mem_rvalid_i = rv_q | rv_force;
  assign mem_rdata_i  = rv_force ? force_data : rv_data;

  function automatic logic [31:0] rd_word(logic [29:0] k);
    return mem_model.exists(k) ? mem_model[k] : 32'h0;
  endfunction

  always @(posedge clk) begin
    logic [31:0] w;
    rv_q <= 1'b0;
    if (rv_cnt > 0) begin
      if (rv_cnt == 1) begin
        rv_q    <= 1'b1;
        rv_data <= rd_word(rv_word);
      end
      rv_cnt <= rv_cnt - 1;
    end
    if (mem_req_o && mem_gnt_i) begin
      if (mem_we_o) begin
        w = rd_word(mem_addr_o[31:2]);
        for (int b = 0; b < 4; b++) if (!mem_web_o[b]) w[b*8 +: 8] = mem_wdata_o[b*8 +: 8];
        mem_model[mem_addr_o[31:2]] = w;
        drn_addr.push_back(mem_addr_o);
        drn_data.push_back(mem_wdata_o);
      end else begin
        rv_word <= mem_addr_o[31:2];
        if (rv_lat == 1) begin
          rv_q    <= 1'b1;
          rv_data <= rd_word(mem_addr_o[31:2]);
        end else begin
          rv_cnt <= rv_lat - 1;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    cpu_rd_i    = 1'b0;
    cpu_web_i   = 4'hF;
    cpu_addr_i  = '0;
    cpu_wdata_i = '0;
  endtask

  task automatic store(input logic [31:0] addr, input logic [3:0] web,
                       input logic [31:0] data, input logic exp_stall);
    step();
    cpu_rd_i = 1'b0; cpu_web_i = web; cpu_addr_i = addr; cpu_wdata_i = data;
    mem_gnt_i = 1'b0;
    @(negedge clk);
    check("store_stall", stall_o, exp_stall);
  endtask

  // Present a load until stall drops; grant is pulsed in cycle 1+gnt_delay.
  task automatic do_load(input logic [31:0] addr, input int gnt_delay,
                         output logic [31:0] data, output int stalls,
                         output logic ld_seen, output logic [31:0] ld_addr,
                         output logic drain_seen);
    logic done = 1'b0;
    stalls = 0; ld_seen = 1'b0; ld_addr = '0; drain_seen = 1'b0; data = '0;
    for (int k = 0; k < 60; k++) begin
      step();
      cpu_rd_i = 1'b1; cpu_web_i = 4'hF; cpu_addr_i = addr; cpu_wdata_i = '0;
      mem_gnt_i = (k == 1 + gnt_delay);
      @(negedge clk);
      if (mem_req_o && !mem_we_o) begin ld_seen = 1'b1; ld_addr = mem_addr_o; end
      if (mem_req_o && mem_we_o) drain_seen = 1'b1;
      if (!stall_o) begin data = cpu_rdata_o; done = 1'b1; break; end
      stalls++;
    end
    check("load_completes", done, 1'b1);
  endtask

  task automatic drain_all();
    logic done = 1'b0;
    for (int k = 0; k < 40; k++) begin
      step();
      idle_inputs();
      mem_gnt_i = 1'b1;
      @(negedge clk);
      if (sb_empty_o) begin done = 1'b1; break; end
    end
    check("drain_done", done, 1'b1);
    step();
    mem_gnt_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] d, la;
    int          st;
    logic        lds, dsn, any_stall;

    rst = 1'b1; mem_gnt_i = 1'b0; idle_inputs();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_stall", stall_o, 1'b0);
    check("rst_req", mem_req_o, 1'b0);
    check("rst_we", mem_we_o, 1'b0);
    check("rst_web", mem_web_o, 4'hF);
    check("rst_addr", mem_addr_o, 32'h0);
    check("rst_wdata", mem_wdata_o, 32'h0);
    check("rst_rdata", cpu_rdata_o, 32'h0);
    check("rst_empty", sb_empty_o, 1'b1);
    check("rst_count", sb_count_o, 3'd0);

    // Fill to DEPTH, fifth store stalls, then drains in order.
    store(32'h100, 4'h0, 32'h11111111, 1'b0);
    store(32'h104, 4'h0, 32'h22222222, 1'b0);
    store(32'h108, 4'h0, 32'h33333333, 1'b0);
    store(32'h10C, 4'h0, 32'h44444444, 1'b0);
    store(32'h110, 4'h0, 32'h55555555, 1'b1);
    check("full_count", sb_count_o, 3'd4);
    step();
    mem_gnt_i = 1'b1;
    @(negedge clk);
    check("full_gnt_stall", stall_o, 1'b0);
    check("full_head_addr", mem_addr_o, 32'h100);
    drain_all();
    check("drain_len", drn_addr.size(), 5);
    for (int i = 0; i < 5 && i < drn_addr.size(); i++) begin
      check($sformatf("drain_addr%0d", i), drn_addr[i], 32'h100 + 32'(4 * i));
      check($sformatf("drain_data%0d", i), drn_data[i], 32'h11111111 * 32'(i + 1));
    end

    // Full-word forward hit.
    store(32'h200, 4'h0, 32'hAABBCCDD, 1'b0);
    do_load(32'h200, 0, d, st, lds, la, dsn);
    check("hit_data", d, 32'hAABBCCDD);
    check("hit_stalls", st, 0);
    check("hit_no_memload", lds, 1'b0);
    drain_all();

    // Partial forward merged with memory data.
    mem_model[30'(32'h300 >> 2)] = 32'h12345678;
    rv_lat = 2;
    store(32'h300, 4'b1110, 32'h000000EE, 1'b0);
    do_load(32'h300, 0, d, st, lds, la, dsn);
    check("merge_data", d, 32'h123456EE);
    check("merge_stalls", st, 4);
    check("merge_memload", lds, 1'b1);
    check("merge_ld_addr", la, 32'h300);
    check("merge_count", sb_count_o, 3'd1);
    drain_all();

    // Youngest store wins per byte.
    store(32'h400, 4'h0, 32'h11111111, 1'b0);
    store(32'h400, 4'b1100, 32'h00002222, 1'b0);
    do_load(32'h400, 0, d, st, lds, la, dsn);
    check("young_data", d, 32'h11112222);
    check("young_stalls", st, 0);

    // Miss with late grant: drain paused, count frozen.
    mem_model[30'(32'h500 >> 2)] = 32'hCAFEF00D;
    rv_lat = 1;
    do_load(32'h500, 3, d, st, lds, la, dsn);
    check("late_data", d, 32'hCAFEF00D);
    check("late_stalls", st, 6);
    check("late_no_drain", dsn, 1'b0);
    check("late_count", sb_count_o, 3'd2);
    drain_all();

    // Reset while waiting for read data.
    rv_lat = 8;
    store(32'h700, 4'h0, 32'h00000077, 1'b0);
    step();
    cpu_rd_i = 1'b1; cpu_web_i = 4'hF; cpu_addr_i = 32'h600;
    step();
    mem_gnt_i = 1'b1;
    step();
    mem_gnt_i = 1'b0;
    @(negedge clk);
    check("wait_stall", stall_o, 1'b1);
    step();
    rst = 1'b1; idle_inputs();
    step();
    rst = 1'b0; rv_force = 1'b1; force_data = 32'hDEADBEEF;
    @(negedge clk);
    check("rstld_stall", stall_o, 1'b0);
    check("rstld_rdata", cpu_rdata_o, 32'h0);
    check("rstld_empty", sb_empty_o, 1'b1);
    check("rstld_count", sb_count_o, 3'd0);
    check("rstld_req", mem_req_o, 1'b0);
    step();
    rv_force = 1'b0;
    any_stall = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (stall_o || cpu_rdata_o != 32'h0 || mem_req_o) any_stall = 1'b1;
    end
    check("rstld_quiet", any_stall, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
